// File: rtl/ps2_note_decoder_if.sv
// Byte stream in, note events / held pitch out, between the PS/2 receiver and the tone stage.
interface ps2_note_decoder_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        note_valid;
   logic [4:0]  note_code;
   logic        note_on;
   logic [20:0] key_mask;
   logic [4:0]  held_note;
   logic [19:0] tune_div;

   modport master (
      output byte_valid, byte_data,
      input  note_valid, note_code, note_on, key_mask, held_note, tune_div
   );

   modport slave (
      input  byte_valid, byte_data,
      output note_valid, note_code, note_on, key_mask, held_note, tune_div
   );
endinterface

// File: rtl/ps2_note_decoder.sv
// PS/2 scan-code parser producing note events, a 21-key held mask and the sounding pitch.
// Optional octave shift on '-' / '=' keys is enabled by defining NOTE_OCTAVE_SHIFT_EN.
module ps2_note_decoder (
   input logic                i_clk,
   input logic                i_rst_n,
   ps2_note_decoder_if.slave  io_bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic        w_isMake;
   logic        w_isBreak;
   logic [4:0]  w_note;
   logic [20:0] w_bitSel;
   logic        w_noteHeld;

   logic [20:0] r_keyMask;
   logic        r_noteValid;
   logic [4:0]  r_noteCode;
   logic        r_noteOn;
   logic [4:0]  r_recent;
   logic [4:0]  r_heldNote;
   logic [19:0] r_tuneDiv;
   logic [4:0]  w_heldNext;
   logic [19:0] w_basePitch;
   logic [19:0] w_tuneNext;

`ifdef NOTE_OCTAVE_SHIFT_EN
   logic        w_octDown;
   logic        w_octUp;
   logic [1:0]  r_octOffset;
`endif

   function automatic logic [4:0] mapCode(input logic [7:0] code);
      logic [4:0] result;
      case (code)
         8'h1A: result = 5'd1;
         8'h22: result = 5'd2;
         8'h21: result = 5'd3;
         8'h2A: result = 5'd4;
         8'h32: result = 5'd5;
         8'h31: result = 5'd6;
         8'h3A: result = 5'd7;
         8'h1C: result = 5'd8;
         8'h1B: result = 5'd9;
         8'h23: result = 5'd10;
         8'h2B: result = 5'd11;
         8'h34: result = 5'd12;
         8'h33: result = 5'd13;
         8'h3B: result = 5'd14;
         8'h15: result = 5'd15;
         8'h1D: result = 5'd16;
         8'h24: result = 5'd17;
         8'h2D: result = 5'd18;
         8'h2C: result = 5'd19;
         8'h35: result = 5'd20;
         8'h3C: result = 5'd21;
         default: result = 5'd0;
      endcase
      return result;
   endfunction

   // Half-period counts for C4..B4 at 100 MHz; other octaves are derived by shifting.
   function automatic logic [19:0] midPitch(input logic [2:0] idx);
      logic [19:0] result;
      case (idx)
         3'd0: result = 20'd191110;
         3'd1: result = 20'd170265;
         3'd2: result = 20'd151685;
         3'd3: result = 20'd143172;
         3'd4: result = 20'd127551;
         3'd5: result = 20'd113636;
         3'd6: result = 20'd101239;
         default: result = 20'd0;
      endcase
      return result;
   endfunction

   function automatic logic [19:0] notePitch(input logic [4:0] note);
      logic [19:0] result;
      logic [4:0]  idx;
      result = 20'd0;
      idx    = 5'd0;
      if (note == 5'd0) begin
         result = 20'd0;
      end else if (note <= 5'd7) begin
         idx    = note - 5'd1;
         result = midPitch(idx[2:0]) << 1;
      end else if (note <= 5'd14) begin
         idx    = note - 5'd8;
         result = midPitch(idx[2:0]);
      end else if (note <= 5'd21) begin
         idx    = note - 5'd15;
         result = midPitch(idx[2:0]) >> 1;
      end
      return result;
   endfunction

   assign w_note     = mapCode(io_bus.byte_data);
   assign w_bitSel   = 21'd1 << (w_note - 5'd1);
   assign w_noteHeld = |(r_keyMask & w_bitSel);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Prefix parser: only a plain make from IDLE or a plain break from BRK touches notes.
   always_comb begin
      w_stateNext = r_state;
      w_isMake    = 1'b0;
      w_isBreak   = 1'b0;
`ifdef NOTE_OCTAVE_SHIFT_EN
      w_octDown   = 1'b0;
      w_octUp     = 1'b0;
`endif
      if (io_bus.byte_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (io_bus.byte_data == 8'hF0) begin
                  w_stateNext = ST_BRK;
               end else if (io_bus.byte_data == 8'hE0) begin
                  w_stateNext = ST_EXT;
               end else begin
                  w_isMake = (w_note != 5'd0);
`ifdef NOTE_OCTAVE_SHIFT_EN
                  w_octDown = (io_bus.byte_data == 8'h4E);
                  w_octUp   = (io_bus.byte_data == 8'h55);
`endif
               end
            end
            ST_BRK: begin
               w_stateNext = ST_IDLE;
               w_isBreak   = (w_note != 5'd0);
            end
            ST_EXT: begin
               w_stateNext = (io_bus.byte_data == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
            end
            ST_EXT_BRK: begin
               w_stateNext = ST_IDLE;
            end
            default: begin
               w_stateNext = ST_IDLE;
            end
         endcase
      end
   end

   // Typematic repeats and breaks of unheld keys fall through without an event.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_keyMask   <= 21'd0;
         r_noteValid <= 1'b0;
         r_noteCode  <= 5'd0;
         r_noteOn    <= 1'b0;
         r_recent    <= 5'd0;
      end else begin
         r_noteValid <= 1'b0;
         if (w_isMake && !w_noteHeld) begin
            r_keyMask   <= r_keyMask | w_bitSel;
            r_noteValid <= 1'b1;
            r_noteCode  <= w_note;
            r_noteOn    <= 1'b1;
            r_recent    <= w_note;
         end else if (w_isBreak && w_noteHeld) begin
            r_keyMask   <= r_keyMask & ~w_bitSel;
            r_noteValid <= 1'b1;
            r_noteCode  <= w_note;
            r_noteOn    <= 1'b0;
         end
      end
   end

`ifdef NOTE_OCTAVE_SHIFT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_octOffset <= 2'b00;
      end else if (w_octDown && r_octOffset != 2'b11) begin
         r_octOffset <= r_octOffset - 2'b01;
      end else if (w_octUp && r_octOffset != 2'b01) begin
         r_octOffset <= r_octOffset + 2'b01;
      end
   end
`endif

   // A stale most-recent note (already released) falls back to the highest held key.
   always_comb begin
      w_heldNext = 5'd0;
      for (int k = 0; k < 21; k++) begin
         if (r_keyMask[k]) begin
            w_heldNext = 5'(k + 1);
         end
      end
      if (r_recent != 5'd0 && |(r_keyMask & (21'd1 << (r_recent - 5'd1)))) begin
         w_heldNext = r_recent;
      end
   end

   assign w_basePitch = notePitch(w_heldNext);

   always_comb begin
      w_tuneNext = w_basePitch;
`ifdef NOTE_OCTAVE_SHIFT_EN
      case (r_octOffset)
         2'b11:   w_tuneNext = w_basePitch << 1;
         2'b01:   w_tuneNext = w_basePitch >> 1;
         default: w_tuneNext = w_basePitch;
      endcase
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_heldNote <= 5'd0;
         r_tuneDiv  <= 20'd0;
      end else begin
         r_heldNote <= w_heldNext;
         r_tuneDiv  <= w_tuneNext;
      end
   end

   assign io_bus.note_valid = r_noteValid;
   assign io_bus.note_code  = r_noteCode;
   assign io_bus.note_on    = r_noteOn;
   assign io_bus.key_mask   = r_keyMask;
   assign io_bus.held_note  = r_heldNote;
   assign io_bus.tune_div   = r_tuneDiv;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed bench for ps2_note_decoder: events, typematic, priority, prefixes, reset, octave keys.
module tb_ps2_note_decoder;

   logic clk = 1'b0;
   logic rst_n;
   int   assertCount = 0;
   int   failCount   = 0;
   int   pulseCount  = 0;
   int   pulseBase   = 0;

   ps2_note_decoder_if bus();

   ps2_note_decoder dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.note_valid === 1'b1) pulseCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One byte strobed for a single cycle; returns on the negedge after it was sampled.
   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h15;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      $display("[TB] start");
      rst_n          = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("rst_valid", 32'(bus.note_valid), 32'd0);
      checkOutput("rst_code",  32'(bus.note_code),  32'd0);
      checkOutput("rst_on",    32'(bus.note_on),    32'd0);
      checkOutput("rst_mask",  32'(bus.key_mask),   32'd0);
      checkOutput("rst_held",  32'(bus.held_note),  32'd0);
      checkOutput("rst_tune",  32'(bus.tune_div),   32'd0);
      rst_n = 1'b1;

      applyStimulus(8'h1C);
      checkOutput("mk8_valid", 32'(bus.note_valid), 32'd1);
      checkOutput("mk8_code",  32'(bus.note_code),  32'd8);
      checkOutput("mk8_on",    32'(bus.note_on),    32'd1);
      checkOutput("mk8_mask",  32'(bus.key_mask),   32'h80);
      settle();
      checkOutput("mk8_pulse", 32'(bus.note_valid), 32'd0);
      checkOutput("mk8_held",  32'(bus.held_note),  32'd8);
      checkOutput("mk8_tune",  32'(bus.tune_div),   32'd191110);
      applyStimulus(8'hF0);
      checkOutput("brkpfx_valid", 32'(bus.note_valid), 32'd0);
      applyStimulus(8'h1C);
      checkOutput("br8_valid", 32'(bus.note_valid), 32'd1);
      checkOutput("br8_code",  32'(bus.note_code),  32'd8);
      checkOutput("br8_on",    32'(bus.note_on),    32'd0);
      checkOutput("br8_mask",  32'(bus.key_mask),   32'd0);
      settle();
      checkOutput("br8_held",  32'(bus.held_note),  32'd0);
      checkOutput("br8_tune",  32'(bus.tune_div),   32'd0);

      // Typematic: three back-to-back 1A bytes
      #1 pulseBase = pulseCount;
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h1A;
      repeat (3) @(negedge clk);
      bus.byte_valid = 1'b0;
      settle();
      settle();
      #1;
      checkOutput("typ_pulses", 32'(pulseCount - pulseBase), 32'd1);
      checkOutput("typ_mask",   32'(bus.key_mask),  32'h000001);
      checkOutput("typ_held",   32'(bus.held_note), 32'd1);
      checkOutput("typ_tune",   32'(bus.tune_div),  32'd382220);
      applyStimulus(8'hF0);
      applyStimulus(8'h1A);
      checkOutput("typ_rel_mask", 32'(bus.key_mask), 32'd0);
      settle();

      // Priority: most recent wins, fallback is highest held
      applyStimulus(8'h1C);
      settle();
      checkOutput("pri_held8",  32'(bus.held_note), 32'd8);
      checkOutput("pri_tune8",  32'(bus.tune_div),  32'd191110);
      applyStimulus(8'h15);
      settle();
      checkOutput("pri_held15", 32'(bus.held_note), 32'd15);
      checkOutput("pri_tune15", 32'(bus.tune_div),  32'd95555);
      applyStimulus(8'hF0);
      applyStimulus(8'h15);
      settle();
      checkOutput("pri_back8",  32'(bus.held_note), 32'd8);
      checkOutput("pri_btune8", 32'(bus.tune_div),  32'd191110);
      applyStimulus(8'h1A);
      settle();
      checkOutput("pri_held1",  32'(bus.held_note), 32'd1);
      checkOutput("pri_tune1",  32'(bus.tune_div),  32'd382220);
      applyStimulus(8'h15);
      applyStimulus(8'hF0);
      applyStimulus(8'h15);
      settle();
      checkOutput("pri_fallback", 32'(bus.held_note), 32'd8);
      checkOutput("pri_fb_mask",  32'(bus.key_mask),  32'h81);
      applyStimulus(8'hF0);
      applyStimulus(8'h1A);
      settle();
      checkOutput("pri_rel1_held", 32'(bus.held_note), 32'd8);
      checkOutput("pri_rel1_mask", 32'(bus.key_mask),  32'h80);

      // Extended prefixes, unheld break and non-key bytes produce nothing
      #1 pulseBase = pulseCount;
      applyStimulus(8'hE0);
      applyStimulus(8'h1C);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      applyStimulus(8'h1C);
      applyStimulus(8'hF0);
      applyStimulus(8'h3B);
      applyStimulus(8'hAA);
      applyStimulus(8'hFA);
      settle();
      #1;
      checkOutput("ext_pulses", 32'(pulseCount - pulseBase), 32'd0);
      checkOutput("ext_mask",   32'(bus.key_mask), 32'h80);
      applyStimulus(8'h1A);
      checkOutput("ext_idle_valid", 32'(bus.note_valid), 32'd1);
      checkOutput("ext_idle_code",  32'(bus.note_code),  32'd1);
      checkOutput("ext_idle_on",    32'(bus.note_on),    32'd1);
      applyStimulus(8'hF0);
      applyStimulus(8'h1A);
      checkOutput("ext_rel_on",   32'(bus.note_on),  32'd0);
      checkOutput("ext_rel_mask", 32'(bus.key_mask), 32'h80);
      settle();

      // Reset between F0 and 1C while note 8 is held
      applyStimulus(8'hF0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 32'(bus.note_valid), 32'd0);
      checkOutput("mid_rst_code",  32'(bus.note_code),  32'd0);
      checkOutput("mid_rst_mask",  32'(bus.key_mask),   32'd0);
      checkOutput("mid_rst_held",  32'(bus.held_note),  32'd0);
      checkOutput("mid_rst_tune",  32'(bus.tune_div),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'h1C);
      checkOutput("post_rst_valid", 32'(bus.note_valid), 32'd1);
      checkOutput("post_rst_code",  32'(bus.note_code),  32'd8);
      checkOutput("post_rst_on",    32'(bus.note_on),    32'd1);
      settle();
      checkOutput("post_rst_held",  32'(bus.held_note),  32'd8);

      // Octave keys
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 pulseBase = pulseCount;
      applyStimulus(8'h4E);
      applyStimulus(8'h4E);
      applyStimulus(8'h1C);
      settle();
      #1;
      checkOutput("oct_pulses", 32'(pulseCount - pulseBase), 32'd1);
      checkOutput("oct_held",   32'(bus.held_note), 32'd8);
`ifdef NOTE_OCTAVE_SHIFT_EN
      checkOutput("oct_down_tune", 32'(bus.tune_div), 32'd382220);
`else
      checkOutput("oct_down_tune", 32'(bus.tune_div), 32'd191110);
`endif
      applyStimulus(8'h55);
      applyStimulus(8'h55);
      applyStimulus(8'h55);
      settle();
      #1;
      checkOutput("oct_up_pulses", 32'(pulseCount - pulseBase), 32'd1);
`ifdef NOTE_OCTAVE_SHIFT_EN
      checkOutput("oct_up_tune", 32'(bus.tune_div), 32'd95555);
`else
      checkOutput("oct_up_tune", 32'(bus.tune_div), 32'd191110);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
